seg_instruction_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: it holds the PC, reads the instruction memory, and drives the IF/ID pipeline register consumed by the decode stage. It applies redirects from decode (jumps) and from the branch-resolving stage, honours the load-use stall and flush requests, and halts fetch on a HALT opcode. A write port lets the debug/loader unit fill instruction memory before or during execution.

---
 rtl/seg_instruction_fetch_pkg.sv | 14 +
 rtl/seg_instruction_fetch_if.sv | 40 ++++
 rtl/seg_instruction_fetch_instruction_memory.sv | 24 ++
 rtl/seg_instruction_fetch.sv | 80 ++++++++
 tb/tb_seg_instruction_fetch.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/seg_instruction_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Build option: define IF_HALT_DETECT_EN to enable HALT opcode detection.
package seg_instruction_fetch_pkg;

  localparam logic [5:0]  OPCODE_HALT = 6'b111111;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;
  localparam logic [31:0] PC_RESET    = 32'h0000_0000;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/seg_instruction_fetch_if.sv
// Control, redirect, loader and IF/ID signals of the fetch stage.
// slave = fetch stage side, master = surrounding pipeline side.
interface seg_instruction_fetch_if #(
  parameter int LEN          = 32,
  parameter int NB_IMEM_ADDR = 10
) ();

  logic                    i_enable;
  logic                    i_stall_flag;
  logic                    i_jump_flag;
  logic [LEN-1:0]          i_PC_dir_jump;
  logic                    i_PCSrc;
  logic [LEN-1:0]          i_PC_branch;
  logic                    i_flush;
  logic                    i_wr_en;
  logic [NB_IMEM_ADDR-1:0] i_wr_addr;
  logic [LEN-1:0]          i_wr_data;
  logic [LEN-1:0]          o_PC;
  logic [LEN-1:0]          o_instruction;
  logic                    o_halt;

  modport slave (
    input  i_enable, i_stall_flag,
    input  i_jump_flag, i_PC_dir_jump,
    input  i_PCSrc, i_PC_branch,
    input  i_flush,
    input  i_wr_en, i_wr_addr, i_wr_data,
    output o_PC, o_instruction, o_halt
  );

  modport master (
    output i_enable, i_stall_flag,
    output i_jump_flag, i_PC_dir_jump,
    output i_PCSrc, i_PC_branch,
    output i_flush,
    output i_wr_en, i_wr_addr, i_wr_data,
    input  o_PC, o_instruction, o_halt
  );

endinterface

// File: rtl/seg_instruction_fetch_instruction_memory.sv
// Instruction memory: combinational read, synchronous write.
// A same-cycle write is seen by the read port one cycle later.
module instruction_memory #(
  parameter int LEN          = 32,
  parameter int NB_IMEM_ADDR = 10
) (
  input  logic                    i_clk,
  input  logic                    i_wr_en,
  input  logic [NB_IMEM_ADDR-1:0] i_wr_addr,
  input  logic [LEN-1:0]          i_wr_data,
  input  logic [NB_IMEM_ADDR-1:0] i_rd_addr,
  output logic [LEN-1:0]          o_rd_data
);

  logic [LEN-1:0] mem [2**NB_IMEM_ADDR];

  // loader write port
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/seg_instruction_fetch.sv
// IF stage: PC register, fetch FSM and IF/ID register.
// Build option: IF_HALT_DETECT_EN enables the HALTED state.
module seg_instruction_fetch
  import seg_instruction_fetch_pkg::*;
#(
  parameter int LEN          = 32,
  parameter int NB_IMEM_ADDR = 10,
  parameter int NB_OPCODE    = 6
) (
  input logic                 i_clk,
  input logic                 i_rst,
  seg_instruction_fetch_if.slave bus
);

`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [LEN-1:0] pc;
  logic [LEN-1:0] pc_next;
  logic [LEN-1:0] rd_word;
  logic [LEN-1:0] if_pc;
  logic [LEN-1:0] if_instr;
  logic           halt_hit;
  fetch_state_t   state;

  instruction_memory #(
    .LEN          (LEN),
    .NB_IMEM_ADDR (NB_IMEM_ADDR)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (bus.i_wr_en),
    .i_wr_addr (bus.i_wr_addr),
    .i_wr_data (bus.i_wr_data),
    .i_rd_addr (pc[NB_IMEM_ADDR-1:0]),
    .o_rd_data (rd_word)
  );

  assign pc_next  = pc + 1'b1;
  assign halt_hit = HALT_EN && !bus.i_flush &&
    (rd_word[LEN-1 -: NB_OPCODE] == OPCODE_HALT);

  // PC, FSM and IF/ID register in redirect priority order
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc       <= PC_RESET;
      if_pc    <= '0;
      if_instr <= INSTR_NOP;
      state    <= RUN;
    end else if (bus.i_enable) begin
      if (bus.i_PCSrc) begin
        pc       <= bus.i_PC_branch;
        if_pc    <= '0;
        if_instr <= INSTR_NOP;
        state    <= RUN;
      end else if (state == HALTED) begin
        if_pc    <= '0;
        if_instr <= INSTR_NOP;
      end else if (bus.i_stall_flag) begin
        pc       <= pc;
      end else if (bus.i_jump_flag) begin
        pc       <= bus.i_PC_dir_jump;
        if_pc    <= '0;
        if_instr <= INSTR_NOP;
      end else begin
        pc       <= pc_next;
        if_pc    <= pc_next;
        if_instr <= bus.i_flush ? INSTR_NOP : rd_word;
        if (halt_hit) state <= HALTED;
      end
    end
  end

  assign bus.o_PC          = if_pc;
  assign bus.o_instruction = if_instr;
  assign bus.o_halt        = HALT_EN && (state == HALTED);

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// Directed self-checking bench for seg_instruction_fetch.
// HALT checks follow whether IF_HALT_DETECT_EN is defined.
module tb_seg_instruction_fetch;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  seg_instruction_fetch_if #(.LEN(32), .NB_IMEM_ADDR(10)) bus ();

  seg_instruction_fetch #(
    .LEN          (32),
    .NB_IMEM_ADDR (10),
    .NB_OPCODE    (6)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic if_id(
    input string       tag,
    input logic [31:0] pc,
    input logic [31:0] ins
  );
    check({tag, ".pc"}, bus.o_PC, pc);
    check({tag, ".ins"}, bus.o_instruction, ins);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = a;
    bus.i_wr_data = d;
    step();
    bus.i_wr_en   = 1'b0;
  endtask

  logic exp_h;

  initial begin
    n_chk = 0;
    n_pass = 0;
`ifdef IF_HALT_DETECT_EN
    exp_h = 1'b1;
`else
    exp_h = 1'b0;
`endif
    rst = 1'b1;
    bus.i_enable      = 1'b1;
    bus.i_stall_flag  = 1'b0;
    bus.i_jump_flag   = 1'b0;
    bus.i_PC_dir_jump = '0;
    bus.i_PCSrc       = 1'b0;
    bus.i_PC_branch   = '0;
    bus.i_flush       = 1'b0;
    bus.i_wr_en       = 1'b0;
    bus.i_wr_addr     = '0;
    bus.i_wr_data     = '0;
    step();
    if_id("rst", 32'h0, 32'h0);
    check("rst.halt", {31'b0, bus.o_halt}, 32'h0);

    wr(10'h000, 32'h2001_0005);
    wr(10'h001, 32'h2002_0007);
    wr(10'h002, 32'h0022_1820);
    wr(10'h003, 32'hFC00_0000);
    wr(10'h004, 32'h1111_1111);
    wr(10'h010, 32'h8C0A_0010);
    wr(10'h040, 32'hAC0B_0040);
    rst = 1'b0;

    step(); if_id("f0", 32'h1, 32'h2001_0005);
    step(); if_id("f1", 32'h2, 32'h2002_0007);

    bus.i_stall_flag = 1'b1;
    step(); if_id("stall0", 32'h2, 32'h2002_0007);
    step(); if_id("stall1", 32'h2, 32'h2002_0007);
    bus.i_stall_flag = 1'b0;
    step(); if_id("f2", 32'h3, 32'h0022_1820);

    bus.i_jump_flag   = 1'b1;
    bus.i_PC_dir_jump = 32'h40;
    step(); check("jmp.nop", bus.o_instruction, 32'h0);
    bus.i_jump_flag = 1'b0;
    step(); if_id("jmp.tgt", 32'h41, 32'hAC0B_0040);

    bus.i_PCSrc      = 1'b1;
    bus.i_PC_branch  = 32'h10;
    bus.i_stall_flag = 1'b1;
    bus.i_jump_flag  = 1'b1;
    step(); if_id("br.nop", 32'h0, 32'h0);
    bus.i_PCSrc      = 1'b0;
    bus.i_stall_flag = 1'b0;
    bus.i_jump_flag  = 1'b0;
    step(); if_id("br.tgt", 32'h11, 32'h8C0A_0010);

    bus.i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); if_id($sformatf("en%0d", i), 32'h11, 32'h8C0A_0010);
    end
    bus.i_enable    = 1'b1;
    bus.i_PCSrc     = 1'b1;
    bus.i_PC_branch = 32'h2;
    step(); check("br2.nop", bus.o_instruction, 32'h0);
    bus.i_PCSrc = 1'b0;
    step(); if_id("f2b", 32'h3, 32'h0022_1820);

    step(); if_id("halt.lat", 32'h4, 32'hFC00_0000);
    check("halt.rise", {31'b0, bus.o_halt}, {31'b0, exp_h});
    step();
    if (exp_h) if_id("halt.nop", 32'h0, 32'h0);
    else       if_id("halt.off", 32'h5, 32'h1111_1111);
    check("halt.keep", {31'b0, bus.o_halt}, {31'b0, exp_h});

    bus.i_PCSrc     = 1'b1;
    bus.i_PC_branch = 32'h0;
    step(); if_id("rel.nop", 32'h0, 32'h0);
    check("rel.halt", {31'b0, bus.o_halt}, 32'h0);
    bus.i_PCSrc = 1'b0;
    bus.i_flush = 1'b1;
    step(); if_id("flush", 32'h1, 32'h0);
    bus.i_flush = 1'b0;
    step(); if_id("after.fl", 32'h2, 32'h2002_0007);

    bus.i_PCSrc     = 1'b1;
    bus.i_PC_branch = 32'h3;
    step();
    bus.i_PCSrc = 1'b0;
    step(); if_id("halt2", 32'h4, 32'hFC00_0000);
    rst = 1'b1;
    step(); if_id("rst2", 32'h0, 32'h0);
    check("rst2.halt", {31'b0, bus.o_halt}, 32'h0);
    rst = 1'b0;
    step(); if_id("rst2.f0", 32'h1, 32'h2001_0005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
